// File: rtl/multicycle_control.sv
// Moore controller sequencing a shared-memory multi-cycle MIPS datapath.
// Strobes decode from the current state; mem_ready only gates the memory-step strobes.
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       op,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwritecond,
   output logic             pcwritecondn,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regdest,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsource,
   output logic             illegal,
   output logic             retire,
   output logic [CNT_W-1:0] retired_count,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_REXEC   = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       pcwritecondn;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdest;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       illegal;
      logic       retire;
   } ctl_t;

   localparam logic [2:0] OP_R    = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_J    = 3'b100;
   localparam logic [2:0] OP_BEQ  = 3'b101;
   localparam logic [2:0] OP_BNE  = 3'b110;
   localparam logic [2:0] OP_ADDI = 3'b111;

   state_t           r_state;
   logic [2:0]       r_op_q;
   logic [CNT_W-1:0] r_count;
   ctl_t             w_ctl;

   always_comb begin
      // NOTE: every field gets a default before the case, so no path can infer a latch.
      w_ctl = '0;
      case (r_state)
         S_FETCH: begin
            w_ctl.memread = 1'b1;
            w_ctl.alusrcb = 2'b01;
            w_ctl.irwrite = mem_ready;
            w_ctl.pcwrite = mem_ready;
         end
         S_DECODE: begin
            w_ctl.alusrcb = 2'b11;
            w_ctl.illegal = (op == 3'b000);
         end
         S_MEMADDR, S_ADDIEX: begin
            w_ctl.alusrca = 1'b1;
            w_ctl.alusrcb = 2'b10;
         end
         S_MEMRD: begin
            w_ctl.memread = 1'b1;
            w_ctl.iord    = 1'b1;
         end
         S_MEMWB: begin
            w_ctl.regwrite = 1'b1;
            w_ctl.memtoreg = 1'b1;
            w_ctl.retire   = 1'b1;
         end
         S_MEMWR: begin
            w_ctl.memwrite = 1'b1;
            w_ctl.iord     = 1'b1;
            w_ctl.retire   = mem_ready;
         end
         S_REXEC: begin
            w_ctl.alusrca = 1'b1;
            w_ctl.aluop   = 2'b10;
         end
         S_RWB: begin
            w_ctl.regwrite = 1'b1;
            w_ctl.regdest  = 1'b1;
            w_ctl.retire   = 1'b1;
         end
         S_BRANCH: begin
            w_ctl.alusrca      = 1'b1;
            w_ctl.aluop        = 2'b01;
            w_ctl.pcsource     = 2'b01;
            w_ctl.pcwritecond  = (r_op_q == OP_BEQ);
            w_ctl.pcwritecondn = (r_op_q == OP_BNE);
            w_ctl.retire       = 1'b1;
         end
         S_JUMP: begin
            w_ctl.pcwrite  = 1'b1;
            w_ctl.pcsource = 2'b10;
            w_ctl.retire   = 1'b1;
         end
         S_ADDIWB: begin
            w_ctl.regwrite = 1'b1;
            w_ctl.retire   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every reader sees pre-edge values.
      if (reset) begin
         r_state <= S_FETCH;
         r_op_q  <= '0;
         r_count <= '0;
      end else begin
         if (w_ctl.retire) r_count <= r_count + 1'b1;
         case (r_state)
            S_FETCH:   if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               r_op_q <= op;
               case (op)
                  OP_R:          r_state <= S_REXEC;
                  OP_LW, OP_SW:  r_state <= S_MEMADDR;
                  OP_J:          r_state <= S_JUMP;
                  OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                  OP_ADDI:       r_state <= S_ADDIEX;
                  default:       r_state <= S_FETCH;
               endcase
            end
            S_MEMADDR: r_state <= (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
            S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
            S_REXEC:   r_state <= S_RWB;
            S_ADDIEX:  r_state <= S_ADDIWB;
            // Final steps of every instruction, plus the unreachable encodings, return to fetch.
            default:   r_state <= S_FETCH;
         endcase
      end
   end

   assign {pcwrite, pcwritecond, pcwritecondn, iord, memread, memwrite, irwrite,
           memtoreg, regdest, regwrite, alusrca, alusrcb, aluop, pcsource,
           illegal, retire} = reset ? '0 : w_ctl;
   assign retired_count = reset ? '0 : r_count;
   assign state         = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level step model checked every cycle,
// directed scenarios pinned with literal state sequences, then randomized traffic.
module tb_multicycle_control;

   localparam int CNT_W = 4;
   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADDR = 2, P_MEMRD = 3, P_MEMWB = 4,
                  P_MEMWR = 5, P_REXEC = 6, P_RWB = 7, P_BRANCH = 8, P_JUMP = 9,
                  P_ADDIEX = 10, P_ADDIWB = 11;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       op;
   logic             mem_ready;
   logic             pcwrite, pcwritecond, pcwritecondn, iord, memread, memwrite, irwrite;
   logic             memtoreg, regdest, regwrite, alusrca, illegal, retire;
   logic [1:0]       alusrcb, aluop, pcsource;
   logic [CNT_W-1:0] retired_count;
   logic [3:0]       state;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       pcwritecondn;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdest;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
   } ctl_t;

   ctl_t dut_ctl;
   assign dut_ctl = {pcwrite, pcwritecond, pcwritecondn, iord, memread, memwrite, irwrite,
                     memtoreg, regdest, regwrite, alusrca, alusrcb, aluop, pcsource};

   int total = 0;
   int bad   = 0;

   // Model: position inside the current instruction's step list.
   int         m_idx   = 0;
   logic [2:0] m_op    = '0;
   int         m_cnt   = 0;
   bit         m_valid = 1'b0;

   bit          log_en = 1'b0;
   logic [63:0] seq;
   int          seq_n, ill_seen, ret_seen;

   always #5 clk = ~clk;

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcwritecondn(pcwritecondn),
      .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .illegal(illegal),
      .retire(retire), .retired_count(retired_count), .state(state)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // Step list of one instruction; -1 past its end.
   function automatic int step_of(input logic [2:0] o, input int i);
      int p[6];
      p = '{P_FETCH, P_DECODE, -1, -1, -1, -1};
      case (o)
         3'b001: begin p[2] = P_REXEC;   p[3] = P_RWB; end
         3'b010: begin p[2] = P_MEMADDR; p[3] = P_MEMRD; p[4] = P_MEMWB; end
         3'b011: begin p[2] = P_MEMADDR; p[3] = P_MEMWR; end
         3'b100: p[2] = P_JUMP;
         3'b101, 3'b110: p[2] = P_BRANCH;
         3'b111: begin p[2] = P_ADDIEX;  p[3] = P_ADDIWB; end
         default: ;
      endcase
      return (i >= 0 && i < 6) ? p[i] : -1;
   endfunction

   function automatic ctl_t expect_ctl(input int ph, input logic [2:0] opq, input logic mr);
      ctl_t c = '0;
      case (ph)
         P_FETCH:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
         P_DECODE: c.alusrcb = 2'b11;
         P_MEMADDR, P_ADDIEX: begin c.alusrca = 1; c.alusrcb = 2'b10; end
         P_MEMRD:  begin c.memread = 1; c.iord = 1; end
         P_MEMWB:  begin c.regwrite = 1; c.memtoreg = 1; end
         P_MEMWR:  begin c.memwrite = 1; c.iord = 1; end
         P_REXEC:  begin c.alusrca = 1; c.aluop = 2'b10; end
         P_RWB:    begin c.regwrite = 1; c.regdest = 1; end
         P_BRANCH: begin
            c.alusrca = 1; c.aluop = 2'b01; c.pcsource = 2'b01;
            c.pcwritecond = (opq == 3'b101); c.pcwritecondn = (opq == 3'b110);
         end
         P_JUMP:   begin c.pcwrite = 1; c.pcsource = 2'b10; end
         P_ADDIWB: c.regwrite = 1;
         default: ;
      endcase
      return c;
   endfunction

   always @(negedge clk) begin : compare
      int         ph, nxt;
      logic [2:0] op_path;
      bit         adv, ret;
      if (reset) begin
         check("rst_ctl", dut_ctl, '0);
         check("rst_flags", {illegal, retire}, 2'b00);
         check("rst_state", state, 0);
         check("rst_count", retired_count, 0);
         m_idx = 0; m_op = '0; m_cnt = 0; m_valid = 1'b1;
      end else if (m_valid) begin
         ph      = step_of(m_op, m_idx);
         op_path = (m_idx == 1) ? op : m_op;
         adv     = !(ph == P_FETCH || ph == P_MEMRD || ph == P_MEMWR) || mem_ready;
         ret     = 1'b0;
         nxt     = m_idx;
         if (adv) begin
            if (step_of(op_path, m_idx + 1) < 0) begin
               ret = (m_idx >= 2);
               nxt = 0;
            end else begin
               nxt = m_idx + 1;
            end
         end
         check("state", state, ph);
         check("ctl", dut_ctl, expect_ctl(ph, m_op, mem_ready));
         check("illegal", illegal, (ph == P_DECODE && op == 3'b000));
         check("retire", retire, ret);
         check("count", retired_count, m_cnt);
         m_op  = op_path;
         m_idx = nxt;
         if (ret) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (log_en) begin
         seq = {seq[59:0], state};
         seq_n++;
         if (illegal) ill_seen++;
         if (retire)  ret_seen++;
      end
   end

   task automatic cyc(input logic r, input logic [2:0] o, input logic m);
      reset = r; op = o; mem_ready = m;
      @(posedge clk);
      #1;
   endtask

   task automatic start_log();
      seq = '0; seq_n = 0; ill_seen = 0; ret_seen = 0; log_en = 1'b1;
   endtask

   task automatic end_log(input string name, input logic [63:0] want_seq, input int want_n);
      log_en = 1'b0;
      check({name, "_seq"}, seq, want_seq);
      check({name, "_len"}, seq_n, want_n);
   endtask

   initial begin
      reset = 1'b1; op = '0; mem_ready = 1'b0;
      cyc(1, 3'b000, 1);
      cyc(1, 3'b000, 1);

      // R-type with zero-wait memory.
      start_log();
      cyc(0, 3'b000, 1); cyc(0, 3'b001, 1); cyc(0, 3'b000, 1); cyc(0, 3'b000, 1);
      cyc(0, 3'b000, 0);
      end_log("rtype", 64'h01670, 5);
      check("rtype_retires", ret_seen, 1);
      check("rtype_count", retired_count, 1);

      // lw with two wait cycles in MEMRD.
      start_log();
      cyc(0, 3'b000, 1); cyc(0, 3'b010, 1); cyc(0, 3'b000, 1); cyc(0, 3'b000, 0);
      cyc(0, 3'b000, 0); cyc(0, 3'b000, 1); cyc(0, 3'b000, 1); cyc(0, 3'b000, 0);
      end_log("lw", 64'h01233340, 8);
      check("lw_retires", ret_seen, 1);
      check("lw_count", retired_count, 2);

      // beq then bne with op dropped to 000 after decode.
      start_log();
      cyc(0, 3'b000, 1); cyc(0, 3'b101, 1); cyc(0, 3'b000, 1);
      cyc(0, 3'b000, 1); cyc(0, 3'b110, 1); cyc(0, 3'b000, 1);
      cyc(0, 3'b000, 0);
      end_log("branch", 64'h0180180, 7);
      check("branch_count", retired_count, 4);

      // Undefined opcode.
      start_log();
      cyc(0, 3'b000, 1); cyc(0, 3'b000, 1); cyc(0, 3'b000, 0);
      end_log("illegal", 64'h010, 3);
      check("illegal_pulses", ill_seen, 1);
      check("illegal_retires", ret_seen, 0);
      check("illegal_count", retired_count, 4);

      // Reset while sw waits in MEMWR.
      start_log();
      cyc(0, 3'b000, 1); cyc(0, 3'b011, 1); cyc(0, 3'b000, 1); cyc(0, 3'b000, 0);
      cyc(1, 3'b000, 0);
      end_log("abort", 64'h01250, 5);
      check("abort_state", state, 0);
      check("abort_count", retired_count, 0);
      check("abort_memread", memread, 0);
      reset = 1'b0; mem_ready = 1'b1;
      #1;
      check("release_memread", memread, 1);
      check("release_state", state, 0);

      // 17 jumps wrap the 4-bit counter to 1.
      for (int i = 0; i < 17; i++) begin
         cyc(0, 3'b000, 1); cyc(0, 3'b100, 1); cyc(0, 3'b000, 1);
      end
      check("wrap_count", retired_count, 1);

      // sw with zero-wait memory retires from MEMWR in 4 cycles.
      start_log();
      cyc(0, 3'b000, 1); cyc(0, 3'b011, 1); cyc(0, 3'b000, 1); cyc(0, 3'b000, 1);
      end_log("sw", 64'h0125, 4);
      check("sw_retires", ret_seen, 1);
      check("sw_count", retired_count, 2);
      check("sw_state", state, 0);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) == 0), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM controller that sequences a shared-memory multi-cycle MIPS datapath. It uses the same 3-bit opcode set as the single-cycle decoder. Each instruction is split into fetch, decode, execute, memory and writeback steps, and the block drives the datapath mux selects and write enables for each step. It also handles a variable-latency memory through a ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
op  input  3  opcode field from the instruction register; valid from the DECODE cycle onward
mem_ready  input  1  memory completes the current read or write this cycle
pcwrite  output  1  unconditional PC write
pcwritecond  output  1  PC write if ALU zero (beq)
pcwritecondn  output  1  PC write if ALU not zero (bne)
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memread  output  1  memory read strobe
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
memtoreg  output  1  register write data select: 1 = MDR, 0 = ALUOut
regdest  output  1  destination register select: 1 = rd, 0 = rt
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0 = PC, 1 = reg A
alusrcb  output  2  ALU B select: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
aluop  output  2  00 = add, 01 = sub, 10 = use funct field
pcsource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  output  1  one-cycle pulse on an undefined opcode
retire  output  1  one-cycle pulse when an instruction completes
retired_count  output  CNT_W  retired-instruction count
state  output  4  current state encoding, for debug

Behaviour:
- Opcode encoding: 001 R-type, 010 lw, 011 sw, 100 j, 101 beq, 110 bne, 111 addi, 000 undefined.
- State encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Encodings 12-15 are unreachable; if entered, next state is FETCH and all outputs are 0.
- Reset: while reset=1, state is forced to FETCH, op_q and retired_count are cleared to 0, and every output is held at 0. The first cycle after reset deasserts is FETCH. Reset asserted mid-instruction aborts that instruction with no retire pulse.
- Outputs are decoded from state only (Moore). The exceptions are the mem_ready gating terms listed below. Any output not listed for a state is 0.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target). Latch op into op_q. Next state by op:
  - 001 -> REXEC
  - 010 or 011 -> MEMADDR
  - 100 -> JUMP
  - 101 or 110 -> BRANCH
  - 111 -> ADDIEX
  - 000 -> FETCH, with illegal=1 this cycle and no retire.
- MEMADDR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD if op_q=010, otherwise MEMWR.
- MEMRD: memread=1, iord=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdest=0, retire=1. Next is FETCH.
- MEMWR: memwrite=1, iord=1. Stay until mem_ready=1; in that cycle retire=1 and next is FETCH.
- REXEC: alusrca=1, alusrcb=00, aluop=10. Next is RWB.
- RWB: regwrite=1, regdest=1, memtoreg=0, retire=1. Next is FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01.
  - pcwritecond=1 if op_q=101; pcwritecondn=1 if op_q=110.
  - retire=1, next is FETCH.
- JUMP: pcwrite=1, pcsource=10, retire=1. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next is ADDIWB.
- ADDIWB: regwrite=1, regdest=0, memtoreg=0, retire=1. Next is FETCH.
- Branch, memory and writeback decisions use op_q, not the live op input.
- Latency with zero-wait memory (mem_ready tied to 1):
  - j, beq, bne: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- retired_count increments by 1 on every cycle with retire=1, i.e. on the clock edge that leaves that state. It wraps modulo 2^CNT_W.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset, then mem_ready=1 and op=001 -> state sequence 0,1,6,7,0; retire high only in state 7; retired_count=1; regdest=1 and regwrite=1 only in RWB.
- lw (op=010) with mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; memread=1 and iord=1 held through the waits; memtoreg=1 in MEMWB; retire once.
- beq then bne, with op driven to 000 after DECODE -> BRANCH asserts pcwritecond only for beq and pcwritecondn only for bne; pcsource=01 in both; proves op_q is latched.
- op=000 -> sequence 0,1,0; illegal pulses exactly 1 cycle in DECODE; retire=0; retired_count unchanged.
- reset asserted during MEMWR with mem_ready=0 -> next cycle state=0, all outputs 0, retired_count=0; after release, FETCH with memread=1.
- CNT_W=4, 17 back-to-back j (op=100) -> retired_count reads 1 after wrapping from 15 to 0; sw (op=011) with mem_ready=1 retires in MEMWR in 4 cycles.
